cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: NUM_FU, default 4, number of functional units competing for the common data bus (CDB); legal range 2..8.
REQ-002 Port: clock  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: fu_out_packet  input  NUM_FU x FU_OUT_PACKET  per-FU result packet with fields v (`XLEN), rob_tag, take_branch, done.
REQ-005 Port: squash  input  1  pipeline flush; active-high.
REQ-006 Port: ack  output  NUM_FU  one-hot grant; bit i tells FU i that its result is taken this cycle.
REQ-007 Port: cdb_valid  output  1  CDB carries a valid broadcast this cycle.
REQ-008 Port: cdb_v  output  `XLEN  broadcast result value.
REQ-009 Port: cdb_rob_tag  output  width of FU_OUT_PACKET.rob_tag  ROB entry being completed.
REQ-010 Port: cdb_take_branch  output  1  resolved branch-taken flag.

Function
REQ-011 Request vector: req[i] = fu_out_packet[i].done.
REQ-012 Arbitration SHALL be round-robin: scan from index rr_ptr upward, modulo NUM_FU; the first i with req[i]=1 is granted.
REQ-013 ack SHALL be combinational, same cycle as the request, at most one bit set; ack[i]=1 only if req[i]=1.
REQ-014 ack SHALL be all-zero when reset=1, when squash=1, or when req is all-zero.
REQ-015 On a rising edge with a grant to FU g: cdb_valid<=1; cdb_v, cdb_rob_tag, cdb_take_branch <= fields of fu_out_packet[g]; rr_ptr <= (g+1) mod NUM_FU.
REQ-016 On a rising edge with no grant (no requests, or squash=1): cdb_valid<=0; cdb_v, cdb_rob_tag and cdb_take_branch SHALL hold their previous values; rr_ptr unchanged.
REQ-017 Latency: a result granted in cycle N SHALL appear on the CDB outputs in cycle N+1, for exactly one cycle unless a new grant follows.
REQ-018 No duplicate broadcast: the FU clears done on the edge that samples ack. The arbiter relies on this handshake and SHALL NOT keep any per-FU pending state.
REQ-019 Back-to-back: with several requests present, exactly one result is broadcast per cycle, with no idle cycles between grants.
REQ-020 Fairness: a continuously requesting FU SHALL be granted within NUM_FU cycles.
REQ-021 rr_ptr SHALL be a clog2(NUM_FU)-bit register and SHALL wrap from NUM_FU-1 to 0.
REQ-022 Squash SHALL take effect in the same cycle: no ack, and cdb_valid=0 on the following cycle. A broadcast already registered before the squash cycle SHALL NOT be retracted.

Reset
REQ-023 While reset=1: ack=0 combinationally; on the edge, cdb_valid<=0, cdb_v<=0, cdb_rob_tag<=0, cdb_take_branch<=0, rr_ptr<=0.
REQ-024 Reset asserted mid-operation SHALL drop any in-flight grant. A result from an FU that still shows done after reset SHALL be arbitrated normally, starting from index 0.

Verification
REQ-025 Single request: NUM_FU=4, only FU2 done, v=32'h0000_00AA, rob_tag=5, after reset -> ack=4'b0100 same cycle; next cycle cdb_valid=1, cdb_v=32'hAA, cdb_rob_tag=5; rr_ptr=3.
REQ-026 All four FUs done and held, each FU dropping done after its ack, rr_ptr=0 -> acks 0001, 0010, 0100, 1000 on consecutive cycles; CDB shows FU0..FU3 tags in cycles 1..4; cdb_valid=0 in cycle 5.
REQ-027 Fairness: FU0 and FU1 always re-request (done forced to 1) -> grants alternate FU0, FU1, FU0, FU1 over 4 cycles; neither FU waits more than one cycle.
REQ-028 Squash: FU1 done with squash=1 -> ack=0, next cycle cdb_valid=0, rr_ptr unchanged; squash released -> FU1 granted the following cycle.
REQ-029 Reset mid-stream: FU3 granted (cdb_valid=1 pending), reset asserted for 1 cycle -> ack=0, all CDB outputs 0, rr_ptr=0; FU3 still done after reset -> granted on the first cycle after reset.
REQ-030 Wrap: rr_ptr=3, FU3 and FU0 done -> FU3 granted, then FU0; rr_ptr goes 3 -> 0 -> 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with registered broadcast
`ifndef XLEN
`define XLEN 32
`endif

package cdb_pkg;
  localparam int ROB_TAG_W = 5;

  typedef struct packed {
    logic [`XLEN-1:0]     v;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 take_branch;
    logic                 done;
  } fu_out_packet_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  fu_out_packet_t [NUM_FU-1:0]    fu_out_packet,
  input  logic                           squash,
  output logic [NUM_FU-1:0]              ack,
  output logic                           cdb_valid,
  output logic [`XLEN-1:0]               cdb_v,
  output logic [ROB_TAG_W-1:0]           cdb_rob_tag,
  output logic                           cdb_take_branch
);

  localparam int PTR_W = $clog2(NUM_FU);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] scan_idx [NUM_FU];
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] next_ptr;
  logic             grant;

  // Candidate indices in priority order, starting at the round-robin pointer.
  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx[k] = PTR_W'((int'(rr_ptr) + k) % NUM_FU);
    end
  end

  // First requester in scan order wins; reset and squash block any grant.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (!reset && !squash) begin
      for (int k = NUM_FU - 1; k >= 0; k--) begin
        if (fu_out_packet[scan_idx[k]].done) begin
          grant     = 1'b1;
          grant_idx = scan_idx[k];
        end
      end
    end
    ack = grant ? ({{(NUM_FU-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

  // Pointer moves just past the winner, wrapping at the last FU.
  always_comb begin
    next_ptr = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Register the granted result onto the CDB; payload holds when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid       <= 1'b0;
      cdb_v           <= '0;
      cdb_rob_tag     <= '0;
      cdb_take_branch <= 1'b0;
      rr_ptr          <= '0;
    end else if (grant) begin
      cdb_valid       <= 1'b1;
      cdb_v           <= fu_out_packet[grant_idx].v;
      cdb_rob_tag     <= fu_out_packet[grant_idx].rob_tag;
      cdb_take_branch <= fu_out_packet[grant_idx].take_branch;
      rr_ptr          <= next_ptr;
    end else begin
      cdb_valid       <= 1'b0;
    end
  end

endmodule
